rs232_xmit_arbiter: RTL and testbench
=====================================

Name: rs232_xmit_arbiter

Overview:
- Shares the single rs232_xmit serial transmitter between up to four message sources, e.g. the loopback test reporter, status dumpers and debug printers.
- Grants are round-robin and locked per message, so characters from different sources never interleave mid-line.
- Each requester writes through a byte/last handshake. The arbiter alone drives the transmitter's data and write strobe.
- It waits for transmitter space and inserts a programmable inter-character gap.

Parameters:
N_REQ, 4, number of requesters (2..4; owner_o stays 2 bits)
GAP_CYCLES, 10000, idle clk_i cycles after each strobe before the next byte may be taken
HOLD_TIMEOUT, 65535, cycles the lock is held waiting for the owner's next byte before forced release
CW, 17, width of the gap/timeout counters

Ports:
clk_i  in  1  system clock (FX2 12 MHz domain)
reset_i  in  1  synchronous, active-high reset
req_valid_i  in  N_REQ  requester k has a byte on its data lane
req_data_i  in  8*N_REQ  byte lanes; lane k = bits [8k+7:8k]
req_last_i  in  N_REQ  lane k byte is the final byte of its message
req_ack_o  out  N_REQ  one-cycle pulse: lane k byte accepted
busy_o  out  1  high whenever state is not IDLE
owner_o  out  2  index of the current or last lock holder
timeout_o  out  1  one-cycle pulse when a lock is force-released
xmit_data_o  out  8  byte to rs232_xmit data_i
xmit_write_req_o  out  1  one-cycle strobe to rs232_xmit write_req_i
xmit_space_avail_i  in  1  rs232_xmit space_avail_o

Behaviour:
- All outputs and state are registered.
- Reset values:
  - state IDLE
  - req_ack_o = 0, xmit_write_req_o = 0, timeout_o = 0, busy_o = 0
  - xmit_data_o = 0, owner_o = N_REQ-1, so requester 0 gets first priority
  - counters = 0
- Reset mid-message aborts the message. No strobe or ack is emitted in the reset cycle.
- IDLE:
  - If any req_valid_i is set, pick the first set bit scanning owner_o+1, owner_o+2, … modulo N_REQ.
  - Load owner_o with that index, clear hold_cnt, go to WAIT.
  - If none is set, stay in IDLE.
- WAIT, owner = o:
  - If xmit_space_avail_i and req_valid_i[o]:
    - xmit_data_o <= lane o; xmit_write_req_o <= 1; req_ack_o[o] <= 1
    - last_q <= req_last_i[o]; go to STROBE
  - Otherwise, if !req_valid_i[o]:
    - hold_cnt increments.
    - When hold_cnt == HOLD_TIMEOUT: timeout_o <= 1, go to IDLE (lock released; owner_o kept for rotation).
  - A valid owner blocked only by no space does not advance hold_cnt.
  - Other requesters are ignored while the lock is held.
- STROBE: xmit_write_req_o <= 0; req_ack_o <= 0; gap_cnt <= GAP_CYCLES; go to GAP. Strobe and ack are therefore exactly one cycle wide.
- GAP:
  - If gap_cnt == 0: go to IDLE when last_q, else go to WAIT with hold_cnt cleared.
  - Otherwise gap_cnt decrements.
  - With GAP_CYCLES = 0 the GAP state lasts exactly one cycle.
- Throughput: at most one byte per GAP_CYCLES+3 cycles.
- Latency: the strobe is asserted on the clock edge after a cycle in which WAIT sees space and owner valid.
- Requester protocol:
  - Hold data, last and valid stable until ack.
  - Changes before ack are allowed; the sampled value is whatever is present in the accepting cycle.
- A single-byte message is a byte with last=1 on its first transfer.
- Simultaneous requests are resolved only by the round-robin pointer. No fixed priority exists beyond the reset start point.
- xmit_data_o holds its value between strobes.

Test Plan:
1. Reset, then requester 0 sends "Hi"+LF (last on LF), space_avail=1, GAP_CYCLES=4 → three strobes with data 0x48, 0x69, 0x0A; strobe-to-strobe spacing 7 cycles; three ack pulses on bit 0; busy_o falls after the LF gap.
2. Requesters 0 and 2 both valid with 2-byte messages from IDLE → full message from 0, then full message from 2; no interleave; owner_o goes 0 then 2; next contest between 0 and 2 grants 0 (pointer past 2).
3. space_avail_i held low for 50 cycles while owner valid → no strobe and no ack; strobe the cycle after space rises; timeout_o never pulses.
4. Owner sends a non-last byte then drops valid, HOLD_TIMEOUT=20 → timeout_o pulses once after 20 idle WAIT cycles; a pending requester 1 is then granted.
5. Assert reset_i while in GAP mid-message → next cycle all outputs are at reset values; a subsequent request from requester 0 is served first.
6. GAP_CYCLES=0 with continuous valid → strobes every 3 cycles; each ack coincides with its strobe.

Source files
------------

// File: rtl/rs232_xmit_arbiter.sv
// Round-robin arbiter that locks the shared rs232_xmit transmitter to one message
// source at a time and paces accepted bytes with a programmable inter-character gap.
module rs232_xmit_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned GAP_CYCLES   = 10000,
    parameter int unsigned HOLD_TIMEOUT = 65535,
    parameter int unsigned CW           = 17
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ack_o,
    output logic               busy_o,
    output logic [1:0]         owner_o,
    output logic               timeout_o,
    output logic [7:0]         xmit_data_o,
    output logic               xmit_write_req_o,
    input  logic               xmit_space_avail_i
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STROBE, ST_GAP} state_t;

    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_TIMEOUT);
    localparam logic [1:0]    OWNER_RST = 2'(N_REQ - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [CW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             last_q, last_d;
    logic [N_REQ-1:0] ack_d;
    logic             busy_d, timeout_d, strobe_d;
    logic [1:0]       owner_d;
    logic [7:0]       data_d;

    logic [1:0]       cand;
    logic [1:0]       grant_idx;
    logic             grant_found;
    logic             owner_valid;
    logic [7:0]       owner_lane;

    // First valid requester after the last owner, wrapping modulo N_REQ
    always_comb begin
        cand        = owner_o;
        grant_idx   = owner_o;
        grant_found = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = 2'((32'(owner_o) + i) % N_REQ);
            if (!grant_found && req_valid_i[cand]) begin
                grant_idx   = cand;
                grant_found = 1'b1;
            end
        end
    end

    assign owner_valid = req_valid_i[owner_o];
    assign owner_lane  = req_data_i[int'(owner_o) * 8 +: 8];

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        last_d     = last_q;
        ack_d      = '0;
        strobe_d   = 1'b0;
        timeout_d  = 1'b0;
        owner_d    = owner_o;
        data_d     = xmit_data_o;

        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    owner_d    = grant_idx;
                    hold_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (xmit_space_avail_i && owner_valid) begin
                    data_d         = owner_lane;
                    strobe_d       = 1'b1;
                    ack_d[owner_o] = 1'b1;
                    last_d         = req_last_i[owner_o];
                    state_d        = ST_STROBE;
                end else if (!owner_valid) begin
                    // Owner went quiet mid-message: release the lock eventually
                    if (hold_cnt_q == HOLD_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CW'(1);
                    end
                end
            end
            ST_STROBE: begin
                gap_cnt_d = GAP_LOAD;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    hold_cnt_d = '0;
                    state_d    = last_q ? ST_IDLE : ST_WAIT;
                end else begin
                    gap_cnt_d = gap_cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= ST_IDLE;
            hold_cnt_q       <= '0;
            gap_cnt_q        <= '0;
            last_q           <= 1'b0;
            req_ack_o        <= '0;
            xmit_write_req_o <= 1'b0;
            timeout_o        <= 1'b0;
            busy_o           <= 1'b0;
            xmit_data_o      <= '0;
            owner_o          <= OWNER_RST;
        end else begin
            state_q          <= state_d;
            hold_cnt_q       <= hold_cnt_d;
            gap_cnt_q        <= gap_cnt_d;
            last_q           <= last_d;
            req_ack_o        <= ack_d;
            xmit_write_req_o <= strobe_d;
            timeout_o        <= timeout_d;
            busy_o           <= busy_d;
            xmit_data_o      <= data_d;
            owner_o          <= owner_d;
        end
    end
endmodule

// File: tb/tb_rs232_xmit_arbiter.sv
// Directed bench for rs232_xmit_arbiter: cycle table for a 3-byte message plus
// hand-written sequences for arbitration, back-pressure, timeout, reset and zero gap.
module tb_rs232_xmit_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  valid, last, ack;
    logic [31:0] data;
    logic        space;
    logic        busy, timeout, strobe;
    logic [1:0]  owner;
    logic [7:0]  xd;

    logic [3:0]  valid_z, last_z, ack_z;
    logic [31:0] data_z;
    logic        busy_z, timeout_z, strobe_z;
    logic [1:0]  owner_z;
    logic [7:0]  xd_z;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int to_cnt = 0;
    int to_cyc = 0;

    logic [8:0] lq [4][$];
    logic [7:0] log_d [$];
    logic [1:0] log_o [$];
    int         log_c [$];

    rs232_xmit_arbiter #(.N_REQ(4), .GAP_CYCLES(4), .HOLD_TIMEOUT(20), .CW(17)) dut (
        .clk_i(clk), .reset_i(rst),
        .req_valid_i(valid), .req_data_i(data), .req_last_i(last), .req_ack_o(ack),
        .busy_o(busy), .owner_o(owner), .timeout_o(timeout),
        .xmit_data_o(xd), .xmit_write_req_o(strobe), .xmit_space_avail_i(space)
    );

    rs232_xmit_arbiter #(.N_REQ(4), .GAP_CYCLES(0), .HOLD_TIMEOUT(20), .CW(17)) dut_z (
        .clk_i(clk), .reset_i(rst),
        .req_valid_i(valid_z), .req_data_i(data_z), .req_last_i(last_z), .req_ack_o(ack_z),
        .busy_o(busy_z), .owner_o(owner_z), .timeout_o(timeout_z),
        .xmit_data_o(xd_z), .xmit_write_req_o(strobe_z), .xmit_space_avail_i(space)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         n;
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       s_exp;
        logic       a_exp;
        logic [7:0] xd_exp;
        logic       b_exp;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {15'd0, ack, strobe, busy, timeout, owner, xd};
    endfunction

    task automatic clear_q();
        for (int k = 0; k < 4; k++) lq[k].delete();
        log_d.delete();
        log_o.delete();
        log_c.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid = '0; data = '0; last = '0;
        valid_z = '0; data_z = '0; last_z = '0;
        clear_q();
        to_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", outs(), {15'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00});
        rst = 1'b0;
    endtask

    // One clock with each lane presenting its queue head; pops on ack
    task automatic cycle_q();
        for (int k = 0; k < 4; k++) begin
            valid[k]       = (lq[k].size() != 0);
            data[8*k +: 8] = (lq[k].size() != 0) ? lq[k][0][7:0] : 8'h00;
            last[k]        = (lq[k].size() != 0) ? lq[k][0][8] : 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (strobe) begin
            log_d.push_back(xd);
            log_o.push_back(owner);
            log_c.push_back(cyc);
        end
        if (strobe || ack != 4'b0000)
            check("ack vs strobe", 32'(ack), strobe ? 32'(4'b0001 << owner) : 32'd0);
        if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
        for (int k = 0; k < 4; k++)
            if (ack[k] && lq[k].size() != 0) void'(lq[k].pop_front());
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size() != 0 || busy)
               && n < budget) begin
            cycle_q();
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_strobes(input string name, input int cnt, input int budget);
        int n = 0;
        while (log_d.size() < cnt && n < budget) begin
            cycle_q();
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    task automatic check_log(input string name, input int i, input logic [1:0] o, input logic [7:0] d);
        logic [9:0] got;
        got = (i < log_d.size()) ? {log_o[i], log_d[i]} : 10'h3FF;
        check(name, 32'(got), 32'({o, d}));
    endtask

    initial begin
        int ack_cyc;
        int nstr;
        int sc [$];
        logic [7:0] ctr;

        space = 1'b1;
        do_reset();

        // Test 1: "Hi\n" from requester 0, one row per clock (n = repeat count)
        tbl[0] = '{1, 1'b1, 8'h48, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[1] = '{1, 1'b1, 8'h48, 1'b0, 1'b1, 1'b1, 8'h48, 1'b1};
        tbl[2] = '{6, 1'b1, 8'h69, 1'b0, 1'b0, 1'b0, 8'h48, 1'b1};
        tbl[3] = '{1, 1'b1, 8'h69, 1'b0, 1'b1, 1'b1, 8'h69, 1'b1};
        tbl[4] = '{6, 1'b1, 8'h0A, 1'b1, 1'b0, 1'b0, 8'h69, 1'b1};
        tbl[5] = '{1, 1'b1, 8'h0A, 1'b1, 1'b1, 1'b1, 8'h0A, 1'b1};
        tbl[6] = '{5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b1};
        tbl[7] = '{2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b0};
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < tbl[k].n; r++) begin
                valid = {3'b000, tbl[k].v};
                data  = {24'h0, tbl[k].d};
                last  = {3'b000, tbl[k].l};
                @(posedge clk);
                #1;
                check($sformatf("t1 row %0d.%0d", k, r), outs(),
                      {15'd0, 3'b000, tbl[k].a_exp, tbl[k].s_exp, tbl[k].b_exp, 1'b0, 2'd0, tbl[k].xd_exp});
            end
        end

        // Test 2: requesters 0 and 2 contend; whole messages, no interleave
        do_reset();
        lq[0] = '{9'h0A0, 9'h1A1};
        lq[2] = '{9'h0C0, 9'h1C1};
        drain("t2 drain", 200);
        check("t2 count", 32'(log_d.size()), 32'd4);
        check_log("t2 b0", 0, 2'd0, 8'hA0);
        check_log("t2 b1", 1, 2'd0, 8'hA1);
        check_log("t2 b2", 2, 2'd2, 8'hC0);
        check_log("t2 b3", 3, 2'd2, 8'hC1);
        clear_q();
        lq[0] = '{9'h1B0};
        lq[2] = '{9'h1D2};
        drain("t2 drain2", 200);
        check_log("t2 rotate first", 0, 2'd0, 8'hB0);
        check_log("t2 rotate second", 1, 2'd2, 8'hD2);

        // Test 3: no space for 50 cycles, then strobe on the next edge
        do_reset();
        space = 1'b0;
        lq[0] = '{9'h133};
        repeat (50) cycle_q();
        check("t3 no strobe while full", 32'(log_d.size()), 32'd0);
        check("t3 locked owner", {30'd0, busy, owner == 2'd0}, 32'd3);
        space = 1'b1;
        cycle_q();
        check("t3 strobe after space", {23'd0, strobe, xd}, {23'd0, 1'b1, 8'h33});
        drain("t3 drain", 50);
        check("t3 no timeout", 32'(to_cnt), 32'd0);

        // Test 4: owner stalls after a non-last byte; lock is forced off
        do_reset();
        lq[0] = '{9'h011};
        lq[1] = '{9'h122};
        wait_strobes("t4 first byte", 1, 20);
        ack_cyc = cyc;
        wait_strobes("t4 second byte", 2, 100);
        check("t4 timeout count", 32'(to_cnt), 32'd1);
        check("t4 timeout delay ok", 32'((to_cyc - ack_cyc) >= 26 && (to_cyc - ack_cyc) <= 27), 32'd1);
        check_log("t4 first owner", 0, 2'd0, 8'h11);
        check_log("t4 granted lane1", 1, 2'd1, 8'h22);
        check("t4 lane1 after timeout", 32'(log_c.size() > 1 && log_c[1] > to_cyc), 32'd1);
        drain("t4 drain", 50);

        // Test 5: reset while in GAP mid-message
        do_reset();
        lq[0] = '{9'h055, 9'h156};
        lq[2] = '{9'h177};
        wait_strobes("t5 first byte", 1, 20);
        cycle_q();
        cycle_q();
        rst = 1'b1;
        valid = 4'b0101;
        @(posedge clk);
        #1;
        check("t5 reset mid-gap", outs(), {15'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00});
        rst = 1'b0;
        clear_q();
        lq[1] = '{9'h1E1};
        lq[0] = '{9'h1E0};
        drain("t5 drain", 100);
        check_log("t5 req0 first", 0, 2'd0, 8'hE0);
        check_log("t5 req1 next", 1, 2'd1, 8'hE1);

        // Test 6: zero gap, continuous valid on lane 0 of the second instance
        ctr = 8'h40;
        nstr = 0;
        valid_z = 4'b0001;
        last_z = 4'b0000;
        data_z = {24'h0, ctr};
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (strobe_z || ack_z != 4'b0000) begin
                check("t6 ack with strobe", {27'd0, ack_z, strobe_z}, {27'd0, 4'b0001, 1'b1});
                check("t6 data", 32'(xd_z), 32'(ctr));
                sc.push_back(c);
            end
            if (ack_z[0]) begin
                ctr = ctr + 8'd1;
                data_z = {24'h0, ctr};
            end
        end
        valid_z = 4'b0000;
        nstr = sc.size();
        check("t6 strobe count", 32'(nstr >= 5), 32'd1);
        for (int i = 1; i < nstr; i++)
            check($sformatf("t6 spacing %0d", i), 32'(sc[i] - sc[i-1]), 32'd3);
        check("t6 owner/timeout", {29'd0, owner_z, timeout_z}, {29'd0, 2'd0, 1'b0});
        check("t6 busy", 32'(busy_z), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
